// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs and monitor status bundle for traffic_light_monitor.
// Optional statistics signals exist only when MONITOR_STATS_EN is defined.
`default_nettype none

interface traffic_light_monitor_if;
  logic       red;
  logic       yellow;
  logic       green;
  logic       clear_fault;
  logic [1:0] phase;
  logic       phase_valid;
  logic       synced;
  logic       seq_error;
  logic       time_error;
  logic       illegal_error;
  logic       fault;
`ifdef MONITOR_STATS_EN
  logic [15:0] cycle_count;
  logic [7:0]  error_count;
`endif

  modport master (
`ifdef MONITOR_STATS_EN
    input  cycle_count, error_count,
`endif
    output red, yellow, green, clear_fault,
    input  phase, phase_valid, synced, seq_error, time_error, illegal_error, fault
  );

  modport slave (
`ifdef MONITOR_STATS_EN
    output cycle_count, error_count,
`endif
    input  red, yellow, green, clear_fault,
    output phase, phase_valid, synced, seq_error, time_error, illegal_error, fault
  );
endinterface

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp order and phase dwell times of a R/Y/G light.
// Optional macro MONITOR_STATS_EN adds completed-cycle and error counters.
`default_nettype none

module traffic_light_monitor #(
  parameter int unsigned RED_CYCLES        = 4,
  parameter int unsigned RED_YELLOW_CYCLES = 1,
  parameter int unsigned GREEN_CYCLES      = 5,
  parameter int unsigned YELLOW_CYCLES     = 1,
  parameter int unsigned TOL               = 0
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  traffic_light_monitor_if.slave  mon_io
);

  localparam logic [2:0]  c_PAT_RED    = 3'b100;
  localparam logic [2:0]  c_PAT_RY     = 3'b110;
  localparam logic [2:0]  c_PAT_GREEN  = 3'b001;
  localparam logic [2:0]  c_PAT_YELLOW = 3'b010;
  localparam logic [16:0] c_TOL        = 17'(TOL);

  // Returns {legal, phase code}.
  function automatic logic [2:0] f_decode(input logic [2:0] pat);
    case (pat)
      c_PAT_RED:    f_decode = 3'b100;
      c_PAT_RY:     f_decode = 3'b101;
      c_PAT_GREEN:  f_decode = 3'b110;
      c_PAT_YELLOW: f_decode = 3'b111;
      default:      f_decode = 3'b000;
    endcase
  endfunction

  logic [2:0]  pat_q, pat_d;
  logic [15:0] dwell_q, dwell_d;
  logic        synced_q, synced_d;
  logic [1:0]  phase_q, phase_d;
  logic        phase_valid_q, phase_valid_d;
  logic        seq_err_q, seq_err_d;
  logic        time_err_q, time_err_d;
  logic        ill_err_q, ill_err_d;
  logic        fault_q, fault_d;
  logic        cycle_done;

  logic [2:0]  w_p, w_p_dec, w_pat_dec;
  logic [16:0] w_exp, w_lo, w_hi;

  assign w_p       = {mon_io.red, mon_io.yellow, mon_io.green};
  assign w_p_dec   = f_decode(w_p);
  assign w_pat_dec = f_decode(pat_q);

  always_comb begin
    case (w_pat_dec[1:0])
      2'd0:    w_exp = 17'(RED_CYCLES);
      2'd1:    w_exp = 17'(RED_YELLOW_CYCLES);
      2'd2:    w_exp = 17'(GREEN_CYCLES);
      default: w_exp = 17'(YELLOW_CYCLES);
    endcase
    w_lo = (w_exp < c_TOL) ? 17'd0 : (w_exp - c_TOL);
    w_hi = w_exp + c_TOL + 17'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q         <= 3'b000;
      dwell_q       <= 16'd0;
      synced_q      <= 1'b0;
      phase_q       <= 2'd0;
      phase_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      time_err_q    <= 1'b0;
      ill_err_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      dwell_q       <= dwell_d;
      synced_q      <= synced_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      seq_err_q     <= seq_err_d;
      time_err_q    <= time_err_d;
      ill_err_q     <= ill_err_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    pat_d      = pat_q;
    dwell_d    = dwell_q;
    synced_d   = synced_q;
    seq_err_d  = 1'b0;
    time_err_d = 1'b0;
    ill_err_d  = 1'b0;
    cycle_done = 1'b0;
    if (w_p == pat_q) begin
      if (dwell_q != 16'hFFFF) dwell_d = dwell_q + 16'd1;
      // Equality on the growing count reports an overrun exactly once per phase.
      if (synced_q && w_pat_dec[2] && ({1'b0, dwell_d} == w_hi)) time_err_d = 1'b1;
    end else begin
      pat_d   = w_p;
      dwell_d = 16'd1;
      if (synced_q) begin
        if (!w_p_dec[2])                               ill_err_d  = 1'b1;
        else if (w_p_dec[1:0] != w_pat_dec[1:0] + 2'd1) seq_err_d  = 1'b1;
        else if ({1'b0, dwell_q} < w_lo)               time_err_d = 1'b1;
      end
      // Timing faults keep lock since the order is still known; order/pattern faults drop it.
      synced_d   = (synced_q && !ill_err_d && !seq_err_d) || (w_p == c_PAT_RED);
      cycle_done = synced_q && (pat_q == c_PAT_YELLOW) && (w_p == c_PAT_RED) && !time_err_d;
    end
    phase_valid_d = w_pat_dec[2];
    phase_d       = w_pat_dec[2] ? w_pat_dec[1:0] : phase_q;
    if (seq_err_d || time_err_d || ill_err_d) fault_d = 1'b1;
    else if (mon_io.clear_fault)              fault_d = 1'b0;
    else                                      fault_d = fault_q;
  end

  always_comb begin
    mon_io.phase         = phase_q;
    mon_io.phase_valid   = phase_valid_q;
    mon_io.synced        = synced_q;
    mon_io.seq_error     = seq_err_q;
    mon_io.time_error    = time_err_q;
    mon_io.illegal_error = ill_err_q;
    mon_io.fault         = fault_q;
  end

`ifdef MONITOR_STATS_EN
  logic [15:0] cycle_count_q;
  logic [7:0]  error_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_count_q <= 16'd0;
      error_count_q <= 8'd0;
    end else begin
      if (cycle_done) cycle_count_q <= cycle_count_q + 16'd1;
      if ((seq_err_d || time_err_d || ill_err_d) && (error_count_q != 8'hFF))
        error_count_q <= error_count_q + 8'd1;
    end
  end

  assign mon_io.cycle_count = cycle_count_q;
  assign mon_io.error_count = error_count_q;
`else
  logic w_unused;
  assign w_unused = cycle_done;
`endif

endmodule

`default_nettype wire
